// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mips_pkg
// Description : Shared word width, Booth iteration counts and FSM state type.
// Revision    : 1.0 - initial release
// ============================================================================
package mips_pkg;

    localparam int WORD_W = 32;

    localparam logic [5:0] c_ITER_32 = 6'd32;
    localparam logic [5:0] c_ITER_33 = 6'd33;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/booth_step.sv
`default_nettype none
// ============================================================================
// Module      : booth_step
// Description : One radix-2 Booth add/subtract followed by arithmetic shift.
// Revision    : 1.0 - initial release
// ============================================================================
module booth_step
    import mips_pkg::*;
#(
    parameter int ACC_W = 33,
    parameter int Q_W   = 32
) (
    input  logic [ACC_W-1:0] i_acc,
    input  logic [Q_W-1:0]   i_q,
    input  logic             i_qm1,
    input  logic [ACC_W-1:0] i_mcand,
    output logic [ACC_W-1:0] o_acc,
    output logic [Q_W-1:0]   o_q,
    output logic             o_qm1
);

    logic [ACC_W-1:0] w_sum;

    always_comb begin
        w_sum = i_acc;
        case ({i_q[0], i_qm1})
            2'b01:   w_sum = i_acc + i_mcand;
            2'b10:   w_sum = i_acc - i_mcand;
            default: w_sum = i_acc;
        endcase
    end

    // {acc,Q,Q_-1} shifted right one place with the accumulator sign kept
    assign o_acc = {w_sum[ACC_W-1], w_sum[ACC_W-1:1]};
    assign o_q   = {w_sum[0], i_q[Q_W-1:1]};
    assign o_qm1 = i_q[0];

endmodule
`default_nettype wire

// File: rtl/booth_mult.sv
`default_nettype none
// ============================================================================
// Module      : booth_mult
// Description : Iterative radix-2 Booth multiplier, 32x32 -> 64 bits.
//               Define BOOTH_MULT_MULTU_EN to add the MultU unsigned mode.
// Revision    : 1.0 - initial release
// ============================================================================
module booth_mult
    import mips_pkg::*;
#(
    parameter int WIDTH = WORD_W
) (
    input  logic             clk,
    input  logic             Reset,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
`ifdef BOOTH_MULT_MULTU_EN
    input  logic             MultU,
`endif
    input  logic             MultIn,
    output logic             MultStop,
    output logic             MultBusy,
    output logic [WIDTH-1:0] resultHigh,
    output logic [WIDTH-1:0] resultLow
);

`ifdef BOOTH_MULT_MULTU_EN
    localparam int         OP_W   = WIDTH + 1;
    localparam logic [5:0] c_ITER = c_ITER_33;
`else
    localparam int         OP_W   = WIDTH;
    localparam logic [5:0] c_ITER = c_ITER_32;
`endif
    localparam int ACC_W = OP_W + 1;

    state_t             r_state;
    state_t             w_next_state;
    logic [5:0]         r_cnt;
    logic [ACC_W-1:0]   r_acc;
    logic [ACC_W-1:0]   r_mcand;
    logic [OP_W-1:0]    r_q;
    logic               r_qm1;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;

    logic [OP_W-1:0]    w_a_ext;
    logic [OP_W-1:0]    w_b_ext;
    logic [ACC_W-1:0]   w_acc_next;
    logic [OP_W-1:0]    w_q_next;
    logic               w_qm1_next;
    logic [2*WIDTH-1:0] w_prod;

`ifdef BOOTH_MULT_MULTU_EN
    assign w_a_ext = {A[WIDTH-1] & ~MultU, A};
    assign w_b_ext = {B[WIDTH-1] & ~MultU, B};
`else
    assign w_a_ext = A;
    assign w_b_ext = B;
`endif

    // Low 64 bits of {accumulator, Q} once all iterations have shifted in
    assign w_prod = {r_acc[2*WIDTH-OP_W-1:0], r_q};

    booth_step #(
        .ACC_W (ACC_W),
        .Q_W   (OP_W)
    ) u_step (
        .i_acc   (r_acc),
        .i_q     (r_q),
        .i_qm1   (r_qm1),
        .i_mcand (r_mcand),
        .o_acc   (w_acc_next),
        .o_q     (w_q_next),
        .o_qm1   (w_qm1_next)
    );

    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) r_state <= IDLE;
        else        r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (MultIn) w_next_state = RUN;
            RUN:     if (r_cnt == 6'd0) w_next_state = DONE;
            DONE:    w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            r_cnt   <= 6'd0;
            r_acc   <= '0;
            r_mcand <= '0;
            r_q     <= '0;
            r_qm1   <= 1'b0;
            r_hi    <= '0;
            r_lo    <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (MultIn) begin
                        r_mcand <= {w_a_ext[OP_W-1], w_a_ext};
                        r_acc   <= '0;
                        r_q     <= w_b_ext;
                        r_qm1   <= 1'b0;
                        r_cnt   <= c_ITER;
                    end
                end
                RUN: begin
                    if (r_cnt != 6'd0) begin
                        r_acc <= w_acc_next;
                        r_q   <= w_q_next;
                        r_qm1 <= w_qm1_next;
                        r_cnt <= r_cnt - 6'd1;
                    end else begin
                        r_hi <= w_prod[2*WIDTH-1:WIDTH];
                        r_lo <= w_prod[WIDTH-1:0];
                    end
                end
                default: ;
            endcase
        end
    end

    assign MultStop   = (r_state == DONE);
    assign MultBusy   = (r_state != IDLE);
    assign resultHigh = r_hi;
    assign resultLow  = r_lo;

endmodule
`default_nettype wire

// File: tb/tb_booth_mult.sv
`default_nettype none
// ============================================================================
// Module      : tb_booth_mult
// Description : Randomized scoreboard bench for booth_mult.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_booth_mult;

`ifdef BOOTH_MULT_MULTU_EN
    localparam int LAT = 34;
`else
    localparam int LAT = 33;
`endif

    typedef struct {
        logic [63:0] prod;
        int          start;
    } exp_t;

    logic        clk;
    logic        Reset;
    logic [31:0] A;
    logic [31:0] B;
    logic        MultIn;
    logic        MultStop;
    logic        MultBusy;
    logic [31:0] resultHigh;
    logic [31:0] resultLow;
`ifdef BOOTH_MULT_MULTU_EN
    logic        MultU;
`endif

    int   cyc;
    int   n_tests;
    int   n_fail;
    int   n_stops;
    exp_t sb[$];
    logic [63:0] last_prod;

    booth_mult #(.WIDTH(32)) dut (
        .clk        (clk),
        .Reset      (Reset),
        .A          (A),
        .B          (B),
`ifdef BOOTH_MULT_MULTU_EN
        .MultU      (MultU),
`endif
        .MultIn     (MultIn),
        .MultStop   (MultStop),
        .MultBusy   (MultBusy),
        .resultHigh (resultHigh),
        .resultLow  (resultLow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [63:0] ref_mul(logic [31:0] a, logic [31:0] b, logic u);
        longint          sa, sb;
        longint unsigned ua, ub;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        if (u) return ua * ub;
        return sa * sb;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%h, expected 0x%h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every completion pulse must match the oldest outstanding request
    always @(negedge clk) begin
        if (Reset === 1'b1 && MultStop === 1'b1) begin
            n_stops++;
            if (sb.size() == 0) begin
                check("unexpected_stop", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("product", {resultHigh, resultLow}, e.prod);
                check("latency", 64'(cyc - e.start), 64'(LAT));
                check("busy_at_stop", {63'd0, MultBusy}, 64'd1);
                last_prod = e.prod;
            end
        end
    end

    task automatic start_op(input logic [31:0] a, input logic [31:0] b, input logic u);
        exp_t e;
        @(negedge clk);
        A      = a;
        B      = b;
        MultIn = 1'b1;
`ifdef BOOTH_MULT_MULTU_EN
        MultU  = u;
        e.prod = ref_mul(a, b, u);
`else
        e.prod = ref_mul(a, b, 1'b0);
`endif
        e.start = cyc + 1;
        sb.push_back(e);
        @(negedge clk);
        MultIn = 1'b0;
        A      = $urandom;
        B      = $urandom;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 60) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (sb.size() != 0) begin
            check("timeout", 64'd1, 64'd0);
            sb.delete();
        end
        @(negedge clk);
        #1;
        check("busy_after", {63'd0, MultBusy}, 64'd0);
    endtask

    initial begin
        int s;
        n_tests   = 0;
        n_fail    = 0;
        n_stops   = 0;
        last_prod = 64'd0;
        Reset     = 1'b0;
        MultIn    = 1'b0;
        A         = 32'd0;
        B         = 32'd0;
`ifdef BOOTH_MULT_MULTU_EN
        MultU     = 1'b0;
`endif
        repeat (2) @(negedge clk);
        check("reset_result", {resultHigh, resultLow}, 64'd0);
        check("reset_flags", {62'd0, MultStop, MultBusy}, 64'd0);
        Reset = 1'b1;

        start_op(32'd3, 32'd5, 1'b0);
        @(negedge clk);
        #1;
        check("busy_running", {63'd0, MultBusy}, 64'd1);
        wait_done();
        start_op(32'hFFFF_FFFF, 32'd1, 1'b0);
        wait_done();
        start_op(32'h8000_0000, 32'h8000_0000, 1'b0);
        wait_done();
        start_op(32'd0, 32'h1234_5678, 1'b0);
        wait_done();
        start_op(32'h7FFF_FFFF, 32'h8000_0000, 1'b0);
        wait_done();
`ifdef BOOTH_MULT_MULTU_EN
        start_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        wait_done();
        check("unsigned_ff", last_prod, 64'hFFFF_FFFE_0000_0001);
`endif

        // Result must hold while idle
        repeat (5) @(negedge clk);
        check("hold", {resultHigh, resultLow}, last_prod);

        // Second request during RUN is ignored
        s = n_stops;
        start_op(32'd7, 32'd9, 1'b0);
        while (cyc < sb[0].start + 9) @(negedge clk);
        A      = 32'd2;
        B      = 32'd2;
        MultIn = 1'b1;
        @(negedge clk);
        MultIn = 1'b0;
        wait_done();
        repeat (40) @(negedge clk);
        check("repulse_stops", 64'(n_stops - s), 64'd1);
        check("repulse_result", {resultHigh, resultLow}, 64'd63);

        // Asynchronous reset mid-operation aborts without a pulse
        s = n_stops;
        start_op(32'd7, 32'd9, 1'b0);
        while (cyc < sb[0].start + 11) @(negedge clk);
        #2;
        Reset = 1'b0;
        #1;
        sb.delete();
        check("abort_result", {resultHigh, resultLow}, 64'd0);
        check("abort_flags", {62'd0, MultStop, MultBusy}, 64'd0);
        repeat (2) @(negedge clk);
        Reset = 1'b1;
        start_op(32'd4, 32'd4, 1'b0);
        wait_done();
        check("abort_stops", 64'(n_stops - s), 64'd1);
        check("after_reset", {resultHigh, resultLow}, 64'd16);

        for (int i = 0; i < 24; i++) begin
            logic [31:0] a, b;
            a = $urandom;
            b = $urandom;
            if (i % 6 == 0) a = 32'h8000_0000;
            if (i % 7 == 1) b = 32'hFFFF_FFFF;
            start_op(a, b, 1'($urandom_range(0, 1)));
            wait_done();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
